// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_pkg : shared types for the pipeline stage register               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package pipe_pkg;

  // Encoding doubles as the held-entry count.
  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FULL     = 2'd1,
    SKIDFULL = 2'd2
  } pipe_state_t;

  localparam int CNT_W = 2;

endpackage
`default_nettype wire

// File: rtl/pipe_entry.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_entry : one ctrl+payload storage word with load enable           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pipe_entry #(
  parameter int W = 56
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_reg : valid/ready pipeline latch with flush, bubble        |
// |                  masking and optional skid entry                      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 48,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  localparam int c_entry_w = CTRL_W + DATA_W;

  pipe_state_t            r_state;
  pipe_state_t            w_state_nxt;
  logic                   w_in_xfer;
  logic                   w_out_xfer;
  logic                   w_main_load;
  logic                   w_skid_load;
  logic [c_entry_w-1:0]   w_in_entry;
  logic [c_entry_w-1:0]   w_main_d;
  logic [c_entry_w-1:0]   w_main_q;
  logic [c_entry_w-1:0]   w_skid_q;

  assign out_valid  = (r_state != EMPTY);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;
  assign w_in_entry = {in_ctrl, in_data};

  always_comb begin
    w_state_nxt = r_state;
    w_main_load = 1'b0;
    w_skid_load = 1'b0;
    w_main_d    = w_in_entry;
    case (r_state)
      EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = FULL;
          w_main_load = 1'b1;
        end
      end
      FULL: begin
        if (w_in_xfer && w_out_xfer) begin
          w_main_load = 1'b1;
        end else if (w_out_xfer) begin
          w_state_nxt = EMPTY;
        end else if (w_in_xfer && (SKID != 0)) begin
          w_state_nxt = SKIDFULL;
          w_skid_load = 1'b1;
        end
      end
      SKIDFULL: begin
        if (w_out_xfer) begin
          w_state_nxt = FULL;
          w_main_load = 1'b1;
          w_main_d    = w_skid_q;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    // A flushed input beat is consumed upstream but never stored.
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_load = 1'b0;
      w_skid_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  pipe_entry #(
    .W (c_entry_w)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_main_load),
    .d     (w_main_d),
    .q     (w_main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic r_in_ready;

      pipe_entry #(
        .W (c_entry_w)
      ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_skid_load),
        .d     (w_in_entry),
        .q     (w_skid_q)
      );

      // Registered ready: low exactly while the skid slot is occupied.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_state_nxt != SKIDFULL);
        end
      end

      assign in_ready = r_in_ready;
    end else begin : g_no_skid
      logic w_unused_skid_load;

      assign w_unused_skid_load = w_skid_load;
      assign w_skid_q           = '0;
      assign in_ready           = !out_valid || out_ready;
    end
  endgenerate

  assign out_ctrl = w_main_q[c_entry_w-1 -: CTRL_W] & {CTRL_W{out_valid}};
  assign out_data = w_main_q[DATA_W-1:0];
  assign count    = r_state;

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for every inter-stage latch in the core (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces the per-stage bit-by-bit flop lists with a single block carrying a valid/ready handshake, synchronous flush, bubble insertion (control bits zeroed when invalid) and an optional skid entry so `in_ready` can be a registered signal. Each upstream stage drives `in_*`; each downstream stage consumes `out_*`.

## Interface
- `DATA_W`, 48: payload bits (npc, mem, alu, …); held on bubble, never zeroed except by reset.
- `CTRL_W`, 8: control bits (RegWrite, MemtoReg, halt, PCS, wreg, …); forced to 0 whenever `out_valid`=0.
- `SKID`, 1: 0 = single entry, `in_ready` combinational; 1 = main + skid entry, `in_ready` registered.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `flush`  in  1  kill all held entries and any input presented this cycle.
- `in_valid`  in  1  upstream has a beat.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_ctrl`  in  CTRL_W  upstream control.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  beat present at output.
- `out_ready`  in  1  downstream consumes the beat (stall = 0).
- `out_ctrl`  out  CTRL_W  control, 0 when `out_valid`=0.
- `out_data`  out  DATA_W  payload.
- `count`  out  2  entries held (0..1, or 0..2 if SKID=1).

## Operation
- Transfer in: `in_valid && in_ready`; transfer out: `out_valid && out_ready`.
- States: EMPTY (count 0), FULL (1), SKIDFULL (2, SKID=1 only).
- EMPTY: in → FULL.
- FULL: in & out → FULL (main reloaded); out only → EMPTY; in only → SKID=1: SKIDFULL (beat into skid), SKID=0: impossible (`in_ready` low).
- SKIDFULL: out → FULL, skid moves to main; in never accepted.
- SKID=0: `in_ready = !out_valid || out_ready`.
- SKID=1: `in_ready` is a flop, 1 iff next state ≠ SKIDFULL.
- `flush`=1: next state EMPTY regardless of handshakes; input beat that cycle is discarded (counted as accepted upstream, never appears at output); out transfer in the flush cycle still completes normally.
- Bubble: `out_ctrl` = main ctrl AND `out_valid`; `out_data` holds last main value.
- Ordering strictly FIFO; no beat duplicated or dropped except by flush.

## Timing
- Reset (rst_n low, async): state EMPTY, `out_valid`=0, `out_ctrl`=0, `out_data`=0, `count`=0, `in_ready`=1 (both modes, registered or derived).
- Latency: beat accepted at edge N is on `out_*` after edge N, i.e. visible in cycle N+1.
- Throughput 1 beat/cycle while `out_ready`=1, both modes.
- SKID=1: first stall cycle absorbs one extra beat; `in_ready` drops the following cycle; rises the cycle after the SKIDFULL→FULL transition.
- Flush and stall together: flush wins, EMPTY next cycle.
- Reset mid-stall: all entries lost, no output beat.
- No combinational path `in_*`→`out_*`; SKID=1 has no `out_ready`→`in_ready` path.

## Structure
- Package `pipe_pkg`: `pipe_state_t` (EMPTY, FULL, SKIDFULL), `CNT_W`=2.
- Sub-module `pipe_entry`: CTRL_W+DATA_W register with load enable and async active-low clear; instantiated once (main) or twice (main+skid).
- Control FSM and handshake logic in the top module.

## Test plan
- Reset then in_valid=1, ctrl=8'h5A, data=48'h1234 one cycle, out_ready=1 -> out_valid=1, ctrl 8'h5A, data 48'h1234 next cycle, then out_valid=0, out_ctrl=0, out_data still 48'h1234.
- Streaming 16 beats data=0..15, out_ready=1 -> 16 consecutive outputs 0..15, in_ready never low, count ≤1.
- SKID=1: beats 1,2,3 streaming, out_ready=0 at beat 2's cycle for 3 cycles -> count reaches 2, in_ready low one cycle after stall start, output order 1,2,3, no loss.
- SKID=0 same stimulus -> in_ready low during stall, count ≤1, order 1,2,3.
- flush while SKIDFULL with in_valid=1 -> next cycle out_valid=0, count=0, out_ctrl=0; the flushed input never appears.
- rst_n pulsed low asynchronously mid-stream with count=2 -> outputs at reset values immediately, in_ready=1 after release.
